// File: rtl/alu_sched_if.sv
// alu_sched_if
// Request/response bundle between the two ALU clients and alu_sched.
//   req_valid[1:0]  client -> sched   per-port request valid
//   req_ready[1:0]  sched -> client   per-port request accept (one-hot or zero)
//   req_a0/b0/a1/b1 client -> sched   16-bit operands for port 0 and port 1
//   req_code0/1     client -> sched   5-bit alu_code for each port
//   rsp_valid[1:0]  sched -> client   per-port response valid (one-hot or zero)
//   rsp_ready[1:0]  client -> sched   per-port response accept
//   rsp_c           sched -> client   16-bit result, shared by both ports
//   rsp_ovf         sched -> client   overflow flag of the result
//   rsp_err         sched -> client   opcode was illegal
interface alu_sched_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_a0;
  logic [15:0] req_b0;
  logic [15:0] req_a1;
  logic [15:0] req_b1;
  logic [4:0]  req_code0;
  logic [4:0]  req_code1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [15:0] rsp_c;
  logic        rsp_ovf;
  logic        rsp_err;

  // Client side: issues requests and consumes responses.
  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, req_code0, req_code1,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_c, rsp_ovf, rsp_err
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, req_code0, req_code1,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_c, rsp_ovf, rsp_err
  );
endinterface

// File: rtl/alu_sched.sv
// alu_sched
// Round-robin scheduler that lets two requesters share one combinational
// 16-bit ALU. A granted operation is registered, presented to the ALU for a
// single EXEC cycle, and the captured result is returned to its owner with a
// valid/ready handshake. Illegal opcodes skip the ALU and answer with rsp_err.
//   clk               single clock, rising edge
//   rst               synchronous active-high reset
//   bus               request/response bundle (alu_sched_if.slave)
//   alu_a, alu_b      operands to the ALU (held between operations)
//   alu_code          opcode to the ALU (held between operations)
//   alu_c, alu_ovf    combinational ALU result and overflow
//   busy              high while an operation is in EXEC or RESP
module alu_sched (
  input  logic        clk,
  input  logic        rst,
  alu_sched_if.slave  bus,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [4:0]  alu_code,
  input  logic [15:0] alu_c,
  input  logic        alu_ovf,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state;
  logic        last_grant;
  logic        owner;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [4:0]  op_code;
  logic [15:0] rsp_c_q;
  logic        rsp_ovf_q;
  logic        rsp_err_q;

  logic        grant_sel;
  logic        accept;
  logic [15:0] sel_a;
  logic [15:0] sel_b;
  logic [4:0]  sel_code;
  logic        sel_legal;

  // Opcode legality table, grouped by the class field code[4:3].
  function automatic logic is_legal(input logic [4:0] code);
    logic ok;
    ok = 1'b0;
    case (code[4:3])
      2'b00: ok = 1'b1;
      2'b01: ok = (code[2:0] == 3'd0) || (code[2:0] == 3'd1) ||
                  (code[2:0] == 3'd2) || (code[2:0] == 3'd4);
      2'b10: ok = (code[2] == 1'b0);
      2'b11: ok = (code[2:0] <= 3'd5);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Round-robin choice: on a tie the port that did not win last time goes.
  always_comb begin
    grant_sel = 1'b0;
    if (bus.req_valid == 2'b11) begin
      grant_sel = ~last_grant;
    end else if (bus.req_valid[1]) begin
      grant_sel = 1'b1;
    end
  end

  // Ready is offered only in IDLE and never while reset is asserted.
  always_comb begin
    bus.req_ready = 2'b00;
    if (!rst && (state == IDLE) && (bus.req_valid != 2'b00)) begin
      bus.req_ready = grant_sel ? 2'b10 : 2'b01;
    end
  end

  assign accept = |(bus.req_valid & bus.req_ready);

  always_comb begin
    sel_a     = grant_sel ? bus.req_a1    : bus.req_a0;
    sel_b     = grant_sel ? bus.req_b1    : bus.req_b0;
    sel_code  = grant_sel ? bus.req_code1 : bus.req_code0;
    sel_legal = is_legal(sel_code);
  end

  // Main FSM. Illegal ops leave the ALU operand registers untouched so the
  // ALU inputs keep showing the last legal operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_a       <= 16'h0000;
      op_b       <= 16'h0000;
      op_code    <= 5'd0;
      rsp_c_q    <= 16'h0000;
      rsp_ovf_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner      <= grant_sel;
            last_grant <= grant_sel;
            if (sel_legal) begin
              op_a    <= sel_a;
              op_b    <= sel_b;
              op_code <= sel_code;
              state   <= EXEC;
            end else begin
              rsp_c_q   <= 16'h0000;
              rsp_ovf_q <= 1'b0;
              rsp_err_q <= 1'b1;
              state     <= RESP;
            end
          end
        end
        EXEC: begin
          rsp_c_q   <= alu_c;
          rsp_ovf_q <= alu_ovf;
          rsp_err_q <= 1'b0;
          state     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready[owner]) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.rsp_valid = 2'b00;
    if (state == RESP) begin
      bus.rsp_valid = owner ? 2'b10 : 2'b01;
    end
  end

  assign bus.rsp_c   = rsp_c_q;
  assign bus.rsp_ovf = rsp_ovf_q;
  assign bus.rsp_err = rsp_err_q;
  assign alu_a       = op_a;
  assign alu_b       = op_b;
  assign alu_code    = op_code;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched
// Directed self-checking bench for alu_sched with a small ALU model that
// supports add (00000), and (01000) and logical shift right (10001).
module tb_alu_sched;

  logic        clk;
  logic        rst;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [4:0]  alu_code;
  logic [15:0] alu_c;
  logic        alu_ovf;
  logic        busy;
  int          checks;
  int          errors;

  alu_sched_if bus ();

  alu_sched dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_code (alu_code),
    .alu_c    (alu_c),
    .alu_ovf  (alu_ovf),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: only the opcodes exercised here produce a nonzero result.
  always_comb begin
    logic [15:0] sum;
    sum     = alu_a + alu_b;
    alu_c   = 16'h0000;
    alu_ovf = 1'b0;
    case (alu_code)
      5'b00000: begin
        alu_c   = sum;
        alu_ovf = (alu_a[15] == alu_b[15]) && (sum[15] != alu_a[15]);
      end
      5'b01000: alu_c = alu_a & alu_b;
      5'b10001: alu_c = alu_a >> alu_b[3:0];
      default: begin
        alu_c   = 16'h0000;
        alu_ovf = 1'b0;
      end
    endcase
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle a little past the rising edge.
  task automatic stepClk();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [1:0] valid,
                               input logic [15:0] a0, input logic [15:0] b0,
                               input logic [4:0] c0,
                               input logic [15:0] a1, input logic [15:0] b1,
                               input logic [4:0] c1);
    bus.req_valid = valid;
    bus.req_a0    = a0;
    bus.req_b0    = b0;
    bus.req_code0 = c0;
    bus.req_a1    = a1;
    bus.req_b1    = b1;
    bus.req_code1 = c1;
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    stepClk();
    stepClk();
    rst = 1'b0;
    #1;
  endtask

  logic [1:0]  tie_grant [3] = '{2'b01, 2'b10, 2'b01};
  logic [15:0] tie_res   [3] = '{16'h0003, 16'h0030, 16'h0003};

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.rsp_ready = 2'b00;
    applyStimulus(2'b11, 16'h0001, 16'h0002, 5'b00000,
                  16'h0010, 16'h0020, 5'b00000);

    // Reset: ready must stay low even with both ports requesting.
    stepClk();
    stepClk();
    checkOutput("rst_req_ready", 16'(bus.req_ready), 16'h0000);
    applyStimulus(2'b00, 16'h0, 16'h0, 5'd0, 16'h0, 16'h0, 5'd0);
    rst = 1'b0;
    #1;
    checkOutput("rst_rsp_valid", 16'(bus.rsp_valid), 16'h0000);
    checkOutput("rst_rsp_c", bus.rsp_c, 16'h0000);
    checkOutput("rst_flags", {13'h0, bus.rsp_ovf, bus.rsp_err, busy}, 16'h0000);
    checkOutput("rst_alu_a", alu_a, 16'h0000);
    checkOutput("rst_alu_b", alu_b, 16'h0000);
    checkOutput("rst_alu_code", 16'(alu_code), 16'h0000);

    // Single AND on port 0.
    applyStimulus(2'b01, 16'h0005, 16'h0003, 5'b01000, 16'h0, 16'h0, 5'd0);
    checkOutput("and_req_ready", 16'(bus.req_ready), 16'h0001);
    stepClk();
    applyStimulus(2'b00, 16'h0, 16'h0, 5'd0, 16'h0, 16'h0, 5'd0);
    checkOutput("and_exec_valid", 16'(bus.rsp_valid), 16'h0000);
    checkOutput("and_exec_busy", 16'(busy), 16'h0001);
    checkOutput("and_alu_a", alu_a, 16'h0005);
    checkOutput("and_alu_code", 16'(alu_code), 16'h0008);
    stepClk();
    checkOutput("and_rsp_valid", 16'(bus.rsp_valid), 16'h0001);
    checkOutput("and_rsp_c", bus.rsp_c, 16'h0001);
    checkOutput("and_rsp_flags", {14'h0, bus.rsp_ovf, bus.rsp_err}, 16'h0000);
    bus.rsp_ready = 2'b01;
    stepClk();
    checkOutput("and_done_valid", 16'(bus.rsp_valid), 16'h0000);
    bus.rsp_ready = 2'b00;

    // Tie after reset: grants alternate 01, 10, 01; responses go to owner only.
    doReset();
    bus.rsp_ready = 2'b11;
    applyStimulus(2'b11, 16'h0001, 16'h0002, 5'b00000,
                  16'h0010, 16'h0020, 5'b00000);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("tie%0d_req_ready", i), 16'(bus.req_ready),
                  16'(tie_grant[i]));
      stepClk();
      checkOutput($sformatf("tie%0d_exec_ready", i), 16'(bus.req_ready), 16'h0000);
      stepClk();
      checkOutput($sformatf("tie%0d_rsp_valid", i), 16'(bus.rsp_valid),
                  16'(tie_grant[i]));
      checkOutput($sformatf("tie%0d_rsp_c", i), bus.rsp_c, tie_res[i]);
      stepClk();
    end
    applyStimulus(2'b00, 16'h0, 16'h0, 5'd0, 16'h0, 16'h0, 5'd0);

    // Illegal code on port 1: answer one cycle after accept, ALU untouched.
    applyStimulus(2'b10, 16'h0, 16'h0, 5'd0, 16'h1234, 16'h5678, 5'b01011);
    checkOutput("ill_req_ready", 16'(bus.req_ready), 16'h0002);
    stepClk();
    applyStimulus(2'b00, 16'h0, 16'h0, 5'd0, 16'h0, 16'h0, 5'd0);
    checkOutput("ill_rsp_valid", 16'(bus.rsp_valid), 16'h0002);
    checkOutput("ill_rsp_c", bus.rsp_c, 16'h0000);
    checkOutput("ill_rsp_err", 16'(bus.rsp_err), 16'h0001);
    checkOutput("ill_alu_code", 16'(alu_code), 16'h0000);
    checkOutput("ill_alu_a", alu_a, 16'h0001);
    stepClk();
    checkOutput("ill_done_valid", 16'(bus.rsp_valid), 16'h0000);

    // Overflow add on port 0 with response backpressure and port 1 pending.
    bus.rsp_ready = 2'b00;
    applyStimulus(2'b01, 16'h7FFF, 16'h0001, 5'b00000, 16'h0, 16'h0, 5'd0);
    checkOutput("ovf_req_ready", 16'(bus.req_ready), 16'h0001);
    stepClk();
    applyStimulus(2'b10, 16'h0, 16'h0, 5'd0, 16'h8001, 16'h0004, 5'b10001);
    stepClk();
    bus.rsp_ready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput($sformatf("bp%0d_rsp_valid", i), 16'(bus.rsp_valid), 16'h0001);
      checkOutput($sformatf("bp%0d_rsp_c", i), bus.rsp_c, 16'h8000);
      checkOutput($sformatf("bp%0d_rsp_ovf", i), 16'(bus.rsp_ovf), 16'h0001);
      checkOutput($sformatf("bp%0d_req_ready", i), 16'(bus.req_ready), 16'h0000);
      stepClk();
    end
    bus.rsp_ready = 2'b01;
    #1;
    checkOutput("bp_release_ready", 16'(bus.req_ready), 16'h0000);
    stepClk();
    bus.rsp_ready = 2'b00;
    #1;
    checkOutput("shr_req_ready", 16'(bus.req_ready), 16'h0002);
    stepClk();
    applyStimulus(2'b00, 16'h0, 16'h0, 5'd0, 16'h0, 16'h0, 5'd0);
    stepClk();
    checkOutput("shr_rsp_valid", 16'(bus.rsp_valid), 16'h0002);
    checkOutput("shr_rsp_c", bus.rsp_c, 16'h0800);
    checkOutput("shr_rsp_ovf", 16'(bus.rsp_ovf), 16'h0000);
    bus.rsp_ready = 2'b10;
    stepClk();
    bus.rsp_ready = 2'b00;

    // Reset during EXEC: transaction dropped, outputs back to reset values.
    applyStimulus(2'b01, 16'h0002, 16'h0003, 5'b00000, 16'h0, 16'h0, 5'd0);
    stepClk();
    applyStimulus(2'b00, 16'h0, 16'h0, 5'd0, 16'h0, 16'h0, 5'd0);
    checkOutput("rx_busy_exec", 16'(busy), 16'h0001);
    rst = 1'b1;
    stepClk();
    rst = 1'b0;
    #1;
    checkOutput("rx_alu_a", alu_a, 16'h0000);
    checkOutput("rx_alu_code", 16'(alu_code), 16'h0000);
    checkOutput("rx_flags", {13'h0, bus.rsp_ovf, bus.rsp_err, busy}, 16'h0000);
    checkOutput("rx_rsp_c", bus.rsp_c, 16'h0000);
    bus.rsp_ready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("rx%0d_rsp_valid", i), 16'(bus.rsp_valid), 16'h0000);
      stepClk();
    end
    applyStimulus(2'b11, 16'h0, 16'h0, 5'd0, 16'h0, 16'h0, 5'd0);
    checkOutput("rx_tie_grant", 16'(bus.req_ready), 16'h0001);
    applyStimulus(2'b00, 16'h0, 16'h0, 5'd0, 16'h0, 16'h0, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
